// File: rtl/instr_fetch.sv
// Instruction fetch unit: program memory loaded word by word in LOAD mode,
// then instructions are issued one at a time with a Valid/Ready handshake.
// The processor acknowledges each issued word with a Done pulse.
module instr_fetch #(
  parameter int DEPTH = 16,  // number of program words, power of two
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Load,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [15:0]   WrData,
  input  logic          Run,
  input  logic          Ready,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Valid,
  output logic [AW-1:0] PC,
  output logic [2:0]    State,
  output logic [7:0]    InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [15:0]     mem [DEPTH];
  logic [DEPTH-1:0] mask;
  logic [15:0]     rd_data;
  logic [AW-1:0]   pc;
  logic [7:0]      count;

  // State register.
  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state decode.
  // NOTE: state_next is defaulted first so no path leaves it unassigned,
  // which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (Load)     state_next = S_LOAD;
        else if (Run) state_next = S_FETCH;
      end
      S_LOAD: begin
        if (!Load) state_next = S_IDLE;
      end
      S_FETCH: begin
        state_next = Run ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        // A completed handshake wins: once transferred, the word must finish.
        if (Ready)     state_next = S_WAIT;
        else if (!Run) state_next = S_IDLE;
      end
      S_WAIT: begin
        if (Done) state_next = Run ? S_FETCH : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs: the word is only exposed while it is being offered.
  always_comb begin
    Valid = (state == S_ISSUE);
    DIN   = Valid ? rd_data : 16'h0000;
  end

  // Program memory write port, active only in LOAD.
  // NOTE: the storage array has no reset; the written mask below is what
  // makes post-reset contents read as zero.
  always_ff @(posedge Clock) begin
    if (state == S_LOAD && WrEn) mem[WrAddr] <= WrData;
  end

  // Written mask, cleared by reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                        mask         <= '0;
    else if (state == S_LOAD && WrEn)   mask[WrAddr] <= 1'b1;
  end

  // Synchronous read in FETCH; unwritten entries read as zero.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)               rd_data <= 16'h0000;
    else if (state == S_FETCH) rd_data <= mask[pc] ? mem[pc] : 16'h0000;
  end

  // PC and completed-instruction counter.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc    <= '0;
      count <= 8'd0;
    end else if (state == S_LOAD && !Load) begin
      pc <= '0;
    end else if (state == S_WAIT && Done) begin
      pc <= pc + AW'(1);
      if (count != 8'hFF) count <= count + 8'd1;
    end
  end

  assign PC         = pc;
  assign State      = state;
  assign InstrCount = count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with hand-computed expected values.
module tb_instr_fetch;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Load, WrEn, Run, Ready, Done;
  logic [3:0]  WrAddr;
  logic [15:0] WrData;
  logic [15:0] DIN;
  logic        Valid;
  logic [3:0]  PC;
  logic [2:0]  State;
  logic [7:0]  InstrCount;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(.DEPTH(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .Load(Load), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .Run(Run), .Ready(Ready), .Done(Done),
    .DIN(DIN), .Valid(Valid), .PC(PC), .State(State), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  // Expected program contents after the load phase.
  function automatic logic [15:0] prog(input logic [3:0] a);
    case (a)
      4'd0:    return 16'h0285;
      4'd1:    return 16'h1045;
      4'd9:    return 16'hBEEF;
      default: return 16'h0000;
    endcase
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Load = 0; WrEn = 0; Run = 0; Ready = 0; Done = 0;
    WrAddr = 4'd0; WrData = 16'h0000;
    tick(); tick();
    n_checks++;
    if (State !== 3'd0 || Valid !== 1'b0 || DIN !== 16'h0000 ||
        PC !== 4'd0 || InstrCount !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: State=%0d Valid=%b DIN=%h PC=%0d Cnt=%0d required 0/0/0000/0/0",
               State, Valid, DIN, PC, InstrCount);
    end
    Resetn = 1'b1;
    tick();
    n_checks++;
    if (State !== 3'd0) begin
      n_fail++; $display("FAIL idle_after_reset: State=%0d required 0", State);
    end
  endtask

  task automatic test_load();
    logic [3:0]  addrs [3] = '{4'd0, 4'd1, 4'd9};
    logic [15:0] datas [3] = '{16'h0285, 16'h1045, 16'hBEEF};
    Load = 1'b1; Run = 1'b1;  // Load must win over Run in IDLE
    tick();
    n_checks++;
    if (State !== 3'd1) begin
      n_fail++; $display("FAIL enter_load: State=%0d required 1", State);
    end
    Run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WrEn = 1'b1; WrAddr = addrs[i]; WrData = datas[i];
      tick();
    end
    WrEn = 1'b0; Load = 1'b0;
    tick();
    n_checks++;
    if (State !== 3'd0 || PC !== 4'd0 || Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL exit_load: State=%0d PC=%0d Valid=%b required 0/0/0", State, PC, Valid);
    end
  endtask

  task automatic test_fetch_issue();
    Run = 1'b1; Ready = 1'b0;
    tick();
    n_checks++;
    if (State !== 3'd2 || Valid !== 1'b0 || DIN !== 16'h0000) begin
      n_fail++;
      $display("FAIL fetch_state: State=%0d Valid=%b DIN=%h required 2/0/0000", State, Valid, DIN);
    end
    tick();
    n_checks++;
    if (State !== 3'd3 || Valid !== 1'b1 || DIN !== 16'h0285 || PC !== 4'd0) begin
      n_fail++;
      $display("FAIL first_issue: State=%0d Valid=%b DIN=%h PC=%0d required 3/1/0285/0",
               State, Valid, DIN, PC);
    end
  endtask

  task automatic test_stall();
    Done = 1'b1;  // must be ignored while issuing
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (State !== 3'd3 || Valid !== 1'b1 || DIN !== 16'h0285 ||
          PC !== 4'd0 || InstrCount !== 8'd0) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: State=%0d Valid=%b DIN=%h PC=%0d Cnt=%0d required 3/1/0285/0/0",
                 i, State, Valid, DIN, PC, InstrCount);
      end
    end
  endtask

  task automatic test_handshake();
    Ready = 1'b1; Done = 1'b1;  // Done in the handshake cycle is ignored
    tick();
    n_checks++;
    if (State !== 3'd4 || Valid !== 1'b0 || DIN !== 16'h0000 ||
        PC !== 4'd0 || InstrCount !== 8'd0) begin
      n_fail++;
      $display("FAIL handshake_to_wait: State=%0d Valid=%b DIN=%h PC=%0d Cnt=%0d required 4/0/0000/0/0",
               State, Valid, DIN, PC, InstrCount);
    end
    tick();
    n_checks++;
    if (State !== 3'd2 || PC !== 4'd1 || InstrCount !== 8'd1) begin
      n_fail++;
      $display("FAIL done_advance: State=%0d PC=%0d Cnt=%0d required 2/1/1", State, PC, InstrCount);
    end
    Done = 1'b0; Ready = 1'b0;
    tick();
    n_checks++;
    if (State !== 3'd3 || DIN !== 16'h1045 || PC !== 4'd1) begin
      n_fail++;
      $display("FAIL second_issue: State=%0d DIN=%h PC=%0d required 3/1045/1", State, DIN, PC);
    end
    Ready = 1'b1; tick();
    Ready = 1'b0; Done = 1'b1; tick();
    Done = 1'b0; tick();
    n_checks++;
    if (State !== 3'd3 || DIN !== 16'h0000 || Valid !== 1'b1 || PC !== 4'd2 ||
        InstrCount !== 8'd2) begin
      n_fail++;
      $display("FAIL unwritten_issue: State=%0d DIN=%h Valid=%b PC=%0d Cnt=%0d required 3/0000/1/2/2",
               State, DIN, Valid, PC, InstrCount);
    end
  endtask

  task automatic test_run_drop();
    Ready = 1'b1; tick();             // ISSUE -> WAIT
    Ready = 1'b0; Run = 1'b0;
    Load = 1'b1;                      // ignored outside IDLE
    WrEn = 1'b1; WrAddr = 4'd0; WrData = 16'hFFFF;  // ignored outside LOAD
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (State !== 3'd4 || PC !== 4'd2 || InstrCount !== 8'd2) begin
        n_fail++;
        $display("FAIL wait_hold%0d: State=%0d PC=%0d Cnt=%0d required 4/2/2", i, State, PC, InstrCount);
      end
    end
    Load = 1'b0; WrEn = 1'b0; Done = 1'b1;
    tick();
    n_checks++;
    if (State !== 3'd0 || PC !== 4'd3 || InstrCount !== 8'd3) begin
      n_fail++;
      $display("FAIL late_done: State=%0d PC=%0d Cnt=%0d required 0/3/3", State, PC, InstrCount);
    end
    Done = 1'b0; Run = 1'b1; tick();  // IDLE -> FETCH
    Run = 1'b0; tick();               // FETCH -> IDLE, PC untouched
    n_checks++;
    if (State !== 3'd0 || PC !== 4'd3) begin
      n_fail++;
      $display("FAIL fetch_abort: State=%0d PC=%0d required 0/3", State, PC);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_pc;
    logic [7:0] exp_cnt;
    exp_pc = 4'd3; exp_cnt = 8'd3;
    Run = 1'b1; Ready = 1'b1; Done = 1'b1;
    tick();  // IDLE -> FETCH
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (State !== 3'd2 || PC !== exp_pc) begin
        n_fail++;
        $display("FAIL b2b_fetch%0d: State=%0d PC=%0d required 2/%0d", k, State, PC, exp_pc);
      end
      tick();
      n_checks++;
      if (State !== 3'd3 || Valid !== 1'b1 || DIN !== prog(exp_pc)) begin
        n_fail++;
        $display("FAIL b2b_issue%0d: State=%0d Valid=%b DIN=%h required 3/1/%h",
                 k, State, Valid, DIN, prog(exp_pc));
      end
      tick(); tick();
      exp_pc  = exp_pc + 4'd1;
      exp_cnt = exp_cnt + 8'd1;
    end
    n_checks++;
    if (PC !== 4'd3 || InstrCount !== 8'd19) begin
      n_fail++;
      $display("FAIL b2b_wrap: PC=%0d Cnt=%0d required 3/19", PC, InstrCount);
    end
    for (int k = 0; k < 240; k++) begin
      tick(); tick(); tick();
    end
    n_checks++;
    if (State !== 3'd2 || PC !== 4'd3 || InstrCount !== 8'd255) begin
      n_fail++;
      $display("FAIL count_saturate: State=%0d PC=%0d Cnt=%0d required 2/3/255", State, PC, InstrCount);
    end
    tick(); tick(); tick();
    n_checks++;
    if (PC !== 4'd4 || InstrCount !== 8'd255) begin
      n_fail++;
      $display("FAIL count_hold: PC=%0d Cnt=%0d required 4/255", PC, InstrCount);
    end
    Run = 1'b0; Ready = 1'b0; Done = 1'b0;
    tick();
    n_checks++;
    if (State !== 3'd0 || PC !== 4'd4) begin
      n_fail++;
      $display("FAIL stop_run: State=%0d PC=%0d required 0/4", State, PC);
    end
  endtask

  task automatic test_reset_mid();
    Load = 1'b1; tick();
    Load = 1'b0; tick();              // back to IDLE, PC cleared
    Run = 1'b1; Ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (State !== 3'd3 || DIN !== 16'h0285 || PC !== 4'd0) begin
      n_fail++;
      $display("FAIL pre_reset_issue: State=%0d DIN=%h PC=%0d required 3/0285/0", State, DIN, PC);
    end
    #2 Resetn = 1'b0;
    #1;
    n_checks++;
    if (Valid !== 1'b0 || PC !== 4'd0 || State !== 3'd0 || DIN !== 16'h0000 ||
        InstrCount !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: Valid=%b PC=%0d State=%0d DIN=%h Cnt=%0d required 0/0/0/0000/0",
               Valid, PC, State, DIN, InstrCount);
    end
    #1 Resetn = 1'b1;
    tick(); tick();
    n_checks++;
    if (State !== 3'd3 || Valid !== 1'b1 || DIN !== 16'h0000 || PC !== 4'd0) begin
      n_fail++;
      $display("FAIL post_reset_read: State=%0d Valid=%b DIN=%h PC=%0d required 3/1/0000/0",
               State, Valid, DIN, PC);
    end
    Run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_fetch_issue();
    test_stall();
    test_handshake();
    test_run_drop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
